// File: rtl/cae_pers_pkg.sv
// Shared types and constants for the dispatch/AEG controller slice.
package cae_pers_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int EXC_BADINST = 0;
  localparam int EXC_BADAEG  = 1;
  localparam int EXC_BUSY    = 2;

  // A single-register file still needs a 1-bit index.
  function automatic int aeg_idx_w(input int num_aeg);
    return (num_aeg > 1) ? $clog2(num_aeg) : 1;
  endfunction

endpackage

// File: rtl/cae_disp_aeg_ctrl_if.sv
// Dispatch bus between the host dispatch unit (master) and the controller (slave).
interface cae_disp_aeg_ctrl_if;

  logic        disp_inst_vld;
  logic [4:0]  disp_inst;
  logic [17:0] disp_aeg_idx;
  logic        disp_aeg_rd;
  logic        disp_aeg_wr;
  logic [63:0] disp_aeg_wr_data;
  logic [17:0] disp_aeg_cnt;
  logic [15:0] disp_exception;
  logic        disp_idle;
  logic        disp_rtn_data_vld;
  logic [63:0] disp_rtn_data;
  logic        disp_stall;

  modport master (
    output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    input  disp_aeg_cnt, disp_exception, disp_idle, disp_rtn_data_vld, disp_rtn_data, disp_stall
  );

  modport slave (
    input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
    output disp_aeg_cnt, disp_exception, disp_idle, disp_rtn_data_vld, disp_rtn_data, disp_stall
  );

endinterface

// File: rtl/cae_aeg_regfile.sv
// NUM_AEG x 64-bit register file: two prioritised write ports, one registered read port, flat view.
module cae_aeg_regfile
  import cae_pers_pkg::*;
#(
  parameter  int NUM_AEG = 16,
  localparam int IW      = aeg_idx_w(NUM_AEG)
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  wa_en,
  input  logic [IW-1:0]         wa_idx,
  input  logic [63:0]           wa_data,
  input  logic                  wb_en,
  input  logic [IW-1:0]         wb_idx,
  input  logic [63:0]           wb_data,
  input  logic                  rd_en,
  input  logic                  rd_ok,
  input  logic [IW-1:0]         rd_idx,
  output logic                  rd_vld,
  output logic [63:0]           rd_data,
  output logic [NUM_AEG*64-1:0] aeg_flat
);

  logic [63:0] regs [NUM_AEG];

  // Port A (dispatch) wins over port B (core) when both target one register.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_AEG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_AEG; i++) begin
        if (wa_en && (wa_idx == IW'(i)))      regs[i] <= wa_data;
        else if (wb_en && (wb_idx == IW'(i))) regs[i] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld  <= rd_en;
      rd_data <= (rd_en && rd_ok) ? regs[rd_idx] : 64'd0;
    end
  end

  always_comb begin
    aeg_flat = '0;
    for (int i = 0; i < NUM_AEG; i++) aeg_flat[64*i +: 64] = regs[i];
  end

endmodule

// File: rtl/cae_disp_aeg_ctrl.sv
// Dispatch/AEG controller: launches the user core, flushes every MC port on completion,
// serves AEG reads/writes and raises dispatch exceptions.
module cae_disp_aeg_ctrl
  import cae_pers_pkg::*;
#(
  parameter  int         NUM_AEG      = 16,
  parameter  int         NUM_MC_PORTS = 4,
  parameter  logic [4:0] INST_START   = 5'd0,
  localparam int         IW           = aeg_idx_w(NUM_AEG)
) (
  input  logic                      clk,
  input  logic                      i_reset_n,
  cae_disp_aeg_ctrl_if.slave        disp,
  output logic                      core_start,
  input  logic                      core_done,
  input  logic                      core_aeg_wr,
  input  logic [IW-1:0]             core_aeg_idx,
  input  logic [63:0]               core_aeg_data,
  output logic [NUM_AEG*64-1:0]     aeg_flat,
  output logic [NUM_MC_PORTS-1:0]   mc_rq_flush,
  input  logic [NUM_MC_PORTS-1:0]   mc_rs_flush_cmplt
);

  state_t                  state;
  logic [NUM_MC_PORTS-1:0] pend;
  logic [NUM_MC_PORTS-1:0] pend_next;
  logic [15:0]             exc_next;
  logic                    disp_in_range;
  logic                    core_in_range;
  logic                    is_start;

  // The range check looks at the whole 18-bit index so aliases of valid registers are rejected.
  assign disp_in_range = (disp.disp_aeg_idx < 18'(NUM_AEG));
  assign core_in_range = (32'(core_aeg_idx) < 32'(NUM_AEG));
  assign is_start      = disp.disp_inst_vld && (disp.disp_inst == INST_START);
  assign pend_next     = pend & ~mc_rs_flush_cmplt;

  always_comb begin
    exc_next              = '0;
    exc_next[EXC_BADINST] = disp.disp_inst_vld && (disp.disp_inst != INST_START);
    exc_next[EXC_BADAEG]  = (disp.disp_aeg_rd || disp.disp_aeg_wr) && !disp_in_range;
    exc_next[EXC_BUSY]    = disp.disp_inst_vld && (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state               <= ST_IDLE;
      pend                <= '0;
      core_start          <= 1'b0;
      mc_rq_flush         <= '0;
      disp.disp_exception <= '0;
    end else begin
      disp.disp_exception <= exc_next;
      core_start          <= 1'b0;
      mc_rq_flush         <= '0;
      case (state)
        ST_IDLE: begin
          if (is_start) begin
            core_start <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            mc_rq_flush <= '1;
            pend        <= '1;
            state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Completions arriving alongside the flush pulse already clear their bits here.
          pend <= pend_next;
          if (pend_next == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign disp.disp_idle    = (state == ST_IDLE);
  assign disp.disp_stall   = (state != ST_IDLE);
  assign disp.disp_aeg_cnt = 18'(NUM_AEG);

  cae_aeg_regfile #(
    .NUM_AEG (NUM_AEG)
  ) u_regfile (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .wa_en     (disp.disp_aeg_wr && disp_in_range),
    .wa_idx    (disp.disp_aeg_idx[IW-1:0]),
    .wa_data   (disp.disp_aeg_wr_data),
    .wb_en     (core_aeg_wr && core_in_range),
    .wb_idx    (core_aeg_idx),
    .wb_data   (core_aeg_data),
    .rd_en     (disp.disp_aeg_rd),
    .rd_ok     (disp_in_range),
    .rd_idx    (disp.disp_aeg_idx[IW-1:0]),
    .rd_vld    (disp.disp_rtn_data_vld),
    .rd_data   (disp.disp_rtn_data),
    .aeg_flat  (aeg_flat)
  );

endmodule

// File: tb/tb_cae_disp_aeg_ctrl.sv
// Directed bench for cae_disp_aeg_ctrl (NUM_AEG=16, NUM_MC_PORTS=4, INST_START=0).
module tb_cae_disp_aeg_ctrl;

  localparam int NUM_AEG = 16;
  localparam int NMC     = 4;

  logic                  clk;
  logic                  i_reset_n;
  logic                  core_start;
  logic                  core_done;
  logic                  core_aeg_wr;
  logic [3:0]            core_aeg_idx;
  logic [63:0]           core_aeg_data;
  logic [NUM_AEG*64-1:0] aeg_flat;
  logic [NMC-1:0]        mc_rq_flush;
  logic [NMC-1:0]        mc_rs_flush_cmplt;
  logic [NUM_AEG*64-1:0] exp_flat;

  int n_checks = 0;
  int n_pass   = 0;

  cae_disp_aeg_ctrl_if dif ();

  cae_disp_aeg_ctrl #(
    .NUM_AEG      (NUM_AEG),
    .NUM_MC_PORTS (NMC),
    .INST_START   (5'd0)
  ) dut (
    .clk               (clk),
    .i_reset_n         (i_reset_n),
    .disp              (dif.slave),
    .core_start        (core_start),
    .core_done         (core_done),
    .core_aeg_wr       (core_aeg_wr),
    .core_aeg_idx      (core_aeg_idx),
    .core_aeg_data     (core_aeg_data),
    .aeg_flat          (aeg_flat),
    .mc_rq_flush       (mc_rq_flush),
    .mc_rs_flush_cmplt (mc_rs_flush_cmplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlat(input string tag);
    for (int i = 0; i < NUM_AEG; i++)
      checkOutput($sformatf("%s_aeg%0d", tag, i), aeg_flat[64*i +: 64], exp_flat[64*i +: 64]);
  endtask

  task automatic clearInputs();
    dif.disp_inst_vld    = 1'b0;
    dif.disp_inst        = 5'd0;
    dif.disp_aeg_idx     = 18'd0;
    dif.disp_aeg_rd      = 1'b0;
    dif.disp_aeg_wr      = 1'b0;
    dif.disp_aeg_wr_data = 64'd0;
    core_done            = 1'b0;
    core_aeg_wr          = 1'b0;
    core_aeg_idx         = 4'd0;
    core_aeg_data        = 64'd0;
    mc_rs_flush_cmplt    = '0;
  endtask

  initial begin
    clearInputs();
    exp_flat  = '0;
    i_reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_idle",  64'(dif.disp_idle), 64'd1);
    checkOutput("rst_stall", 64'(dif.disp_stall), 64'd0);
    checkOutput("rst_cnt",   64'(dif.disp_aeg_cnt), 64'd16);
    checkOutput("rst_exc",   64'(dif.disp_exception), 64'd0);
    checkOutput("rst_vld",   64'(dif.disp_rtn_data_vld), 64'd0);
    checkOutput("rst_start", 64'(core_start), 64'd0);
    checkOutput("rst_flush", 64'(mc_rq_flush), 64'd0);
    i_reset_n = 1'b1;
    tick();

    // Basic write then read of AEG3
    dif.disp_aeg_wr = 1'b1; dif.disp_aeg_idx = 18'd3; dif.disp_aeg_wr_data = 64'hDEAD_BEEF;
    tick();
    clearInputs();
    exp_flat[64*3 +: 64] = 64'hDEAD_BEEF;
    checkFlat("wr3");
    dif.disp_aeg_rd = 1'b1; dif.disp_aeg_idx = 18'd3;
    tick();
    clearInputs();
    checkOutput("rd3_vld",  64'(dif.disp_rtn_data_vld), 64'd1);
    checkOutput("rd3_data", dif.disp_rtn_data, 64'hDEAD_BEEF);
    checkOutput("rd3_exc",  64'(dif.disp_exception), 64'd0);
    tick();
    checkOutput("rd3_vld_off", 64'(dif.disp_rtn_data_vld), 64'd0);

    // Out-of-range read and write at idx 16 (aliases AEG0 in the low bits)
    dif.disp_aeg_rd = 1'b1; dif.disp_aeg_idx = 18'd16;
    tick();
    clearInputs();
    checkOutput("oor_rd_vld",  64'(dif.disp_rtn_data_vld), 64'd1);
    checkOutput("oor_rd_data", dif.disp_rtn_data, 64'd0);
    checkOutput("oor_rd_exc",  64'(dif.disp_exception), 64'h0002);
    tick();
    checkOutput("oor_exc_off", 64'(dif.disp_exception), 64'd0);
    dif.disp_aeg_wr = 1'b1; dif.disp_aeg_idx = 18'd16; dif.disp_aeg_wr_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    clearInputs();
    checkOutput("oor_wr_exc", 64'(dif.disp_exception), 64'h0002);
    tick();
    checkFlat("oor_wr");

    // START, run, completion, flush in two halves
    dif.disp_inst_vld = 1'b1; dif.disp_inst = 5'd0;
    tick();
    clearInputs();
    checkOutput("start_pulse", 64'(core_start), 64'd1);
    checkOutput("run_idle",    64'(dif.disp_idle), 64'd0);
    checkOutput("run_stall",   64'(dif.disp_stall), 64'd1);
    checkOutput("start_exc",   64'(dif.disp_exception), 64'd0);
    tick();
    checkOutput("start_once", 64'(core_start), 64'd0);
    mc_rs_flush_cmplt = 4'hF;
    tick();
    clearInputs();
    checkOutput("cmplt_in_run", 64'(dif.disp_idle), 64'd0);
    core_done = 1'b1;
    tick();
    clearInputs();
    checkOutput("flush_pulse", 64'(mc_rq_flush), 64'hF);
    tick();
    checkOutput("flush_once",  64'(mc_rq_flush), 64'h0);
    checkOutput("flush_stall", 64'(dif.disp_stall), 64'd1);
    mc_rs_flush_cmplt = 4'b0101;
    tick();
    clearInputs();
    checkOutput("half_idle", 64'(dif.disp_idle), 64'd0);
    mc_rs_flush_cmplt = 4'b1010;
    tick();
    clearInputs();
    checkOutput("done_idle",  64'(dif.disp_idle), 64'd1);
    checkOutput("done_stall", 64'(dif.disp_stall), 64'd0);

    // Busy START, then completion arriving with the flush pulse
    dif.disp_inst_vld = 1'b1; dif.disp_inst = 5'd0;
    tick();
    clearInputs();
    checkOutput("start2", 64'(core_start), 64'd1);
    dif.disp_inst_vld = 1'b1; dif.disp_inst = 5'd0;
    tick();
    clearInputs();
    checkOutput("busy_exc",   64'(dif.disp_exception), 64'h0004);
    checkOutput("busy_start", 64'(core_start), 64'd0);
    tick();
    checkOutput("busy_exc_off", 64'(dif.disp_exception), 64'd0);
    core_done = 1'b1;
    tick();
    clearInputs();
    checkOutput("flush2_pulse", 64'(mc_rq_flush), 64'hF);
    mc_rs_flush_cmplt = 4'hF;
    tick();
    clearInputs();
    checkOutput("same_cyc_idle", 64'(dif.disp_idle), 64'd1);
    dif.disp_inst_vld = 1'b1; dif.disp_inst = 5'd7;
    tick();
    clearInputs();
    checkOutput("badinst_exc",   64'(dif.disp_exception), 64'h0001);
    checkOutput("badinst_start", 64'(core_start), 64'd0);
    checkOutput("badinst_idle",  64'(dif.disp_idle), 64'd1);
    core_done = 1'b1;
    tick();
    clearInputs();
    checkOutput("done_in_idle_flush", 64'(mc_rq_flush), 64'd0);
    checkOutput("done_in_idle_idle",  64'(dif.disp_idle), 64'd1);

    // Write-port collisions and read-during-write
    dif.disp_aeg_wr = 1'b1; dif.disp_aeg_idx = 18'd5; dif.disp_aeg_wr_data = 64'd1;
    core_aeg_wr = 1'b1; core_aeg_idx = 4'd5; core_aeg_data = 64'd2;
    tick();
    clearInputs();
    exp_flat[64*5 +: 64] = 64'd1;
    checkFlat("coll_same");
    dif.disp_aeg_wr = 1'b1; dif.disp_aeg_idx = 18'd5; dif.disp_aeg_wr_data = 64'h11;
    core_aeg_wr = 1'b1; core_aeg_idx = 4'd6; core_aeg_data = 64'd2;
    tick();
    clearInputs();
    exp_flat[64*5 +: 64] = 64'h11;
    exp_flat[64*6 +: 64] = 64'd2;
    checkFlat("coll_diff");
    dif.disp_aeg_rd = 1'b1; dif.disp_aeg_wr = 1'b1; dif.disp_aeg_idx = 18'd3;
    dif.disp_aeg_wr_data = 64'hCAFE_F00D_0000_0001;
    tick();
    clearInputs();
    exp_flat[64*3 +: 64] = 64'hCAFE_F00D_0000_0001;
    checkOutput("rdwr_vld",  64'(dif.disp_rtn_data_vld), 64'd1);
    checkOutput("rdwr_data", dif.disp_rtn_data, 64'hDEAD_BEEF);
    checkFlat("rdwr");

    // Asynchronous reset in the middle of a flush with ports 1 and 3 outstanding
    dif.disp_inst_vld = 1'b1; dif.disp_inst = 5'd0;
    tick();
    clearInputs();
    core_done = 1'b1;
    tick();
    clearInputs();
    mc_rs_flush_cmplt = 4'b0101;
    tick();
    clearInputs();
    checkOutput("pre_rst_idle", 64'(dif.disp_idle), 64'd0);
    i_reset_n = 1'b0;
    #1;
    exp_flat = '0;
    checkOutput("mid_rst_idle",  64'(dif.disp_idle), 64'd1);
    checkOutput("mid_rst_stall", 64'(dif.disp_stall), 64'd0);
    checkOutput("mid_rst_flush", 64'(mc_rq_flush), 64'd0);
    checkFlat("mid_rst");
    tick();
    checkOutput("rst_hold_flush", 64'(mc_rq_flush), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
